// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, opcode fields,
// the canonical bubble word, fetch FSM states and IF/ID bundle.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0] HALT_OPCODE_DEF  = 6'b111111;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc_plus4: '0,
    valid:    1'b0
  };

endpackage

// File: rtl/fetch_pc_unit.sv
// PC register and next-PC select for the fetch stage.
// In: clock, reset, stall, halted, halt_hit, branch/jump req+target.
// Out: imem_addr (word addr), pc_plus4, redirect.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_AW = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              halted,
  input  logic              halt_hit,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump_taken,
  input  logic [WORD_W-1:0] jump_target,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              redirect
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] jt_al;
  logic [WORD_W-1:0] bt_al;
  logic              live;
  logic              sel_jump;
  logic              sel_br;
  logic              sel_inc;

  assign jt_al = {jump_target[WORD_W-1:2], 2'b00};
  assign bt_al = {branch_target[WORD_W-1:2], 2'b00};

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  // Halted state ignores every request; stall masks redirects.
  assign live     = ~halted & ~stall;
  assign redirect = live & (jump_taken | branch_taken);

  assign sel_jump = live & jump_taken;
  assign sel_br   = live & ~jump_taken & branch_taken;
  // A HALT word in IF freezes the PC at its own address.
  assign sel_inc  = live & ~jump_taken & ~branch_taken
                  & ~halt_hit;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      sel_jump: pc_d = jt_al;
      sel_br:   pc_d = bt_al;
      sel_inc:  pc_d = pc_plus4;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem addressing, IF/ID register, HALT FSM.
// Ports: clock/reset, stall, branch/jump redirects, imem, IF/ID outs.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_AW = 8,
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump_taken,
  input  logic [WORD_W-1:0] jump_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] instr_id,
  output logic [WORD_W-1:0] pc_plus4_id,
  output logic              valid_id,
  output logic              nop_id,
  output logic              halted,
  output logic [WORD_W-1:0] instr_count
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  if_id_t            if_id_q;
  logic [WORD_W-1:0] pc_plus4;
  logic              redirect;
  logic              halt_hit;
  logic              accept;

  assign halt_hit = imem_data[OP_HI:OP_LO] == HALT_OPCODE;

  fetch_pc_unit #(
    .RESET_PC (RESET_PC),
    .IMEM_AW  (IMEM_AW)
  ) u_pc (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .halted        (halted),
    .halt_hit      (halt_hit),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_taken    (jump_taken),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect)
  );

  assign accept = (state_q == S_RUN) & ~stall & ~redirect;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (accept && halt_hit) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_comb begin
    halted = (state_q == S_HALTED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if_id_q <= IF_ID_BUBBLE;
    end else if (halted || redirect) begin
      if_id_q <= IF_ID_BUBBLE;
    end else if (accept) begin
      if_id_q.instr    <= imem_data;
      if_id_q.pc_plus4 <= pc_plus4;
      if_id_q.valid    <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       instr_count <= '0;
    else if (accept) instr_count <= instr_count + 32'd1;
  end

  assign instr_id    = if_id_q.instr;
  assign pc_plus4_id = if_id_q.pc_plus4;
  assign valid_id    = if_id_q.valid;
  assign nop_id      = ~if_id_q.valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, addresses instruction memory, and drives the IF/ID pipeline register. It consumes the load-use `stall` from the hazard unit, freezing PC and IF/ID. It takes branch/jump redirects from ID and flushes the wrong-path instruction as a bubble. It also detects the HALT instruction and freezes the processor until reset.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_AW`, 8: instruction-memory word-address width.
- `HALT_OPCODE`, 6'b111111: opcode (bits 31:26) that halts fetch.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold request from hazard unit; it changes on negedge and is sampled here on posedge.
- `branch_taken`  in  1  redirect request from ID.
- `branch_target`  in  32  branch destination byte address.
- `jump_taken`  in  1  redirect request from ID.
- `jump_target`  in  32  jump destination byte address.
- `imem_addr`  out  IMEM_AW  word address = `pc[IMEM_AW+1:2]`; combinational from PC.
- `imem_data`  in  32  instruction word; asynchronous-read memory, valid in the same cycle.
- `instr_id`  out  32  IF/ID instruction.
- `pc_plus4_id`  out  32  IF/ID PC+4 of that instruction.
- `valid_id`  out  1  IF/ID holds a real fetched instruction.
- `nop_id`  out  1  IF/ID holds a bubble; always `~valid_id`; propagates to ID/EX as `nop_exe`.
- `halted`  out  1  HALT has been accepted.
- `instr_count`  out  32  count of instructions accepted into IF/ID.

## Operation
- States: RUN and HALTED. Reset puts the block in RUN.
- Leaving HALTED requires reset. HALTED ignores `stall`, `branch_taken`, and `jump_taken`.
- `redirect = (jump_taken | branch_taken) & ~stall`. If both are asserted, jump wins.
- Targets are used with bits 1:0 forced to 0.
- Per-cycle priority in RUN:
  1. reset.
  2. stall: PC, IF/ID, and count all hold.
  3. redirect: `pc <= target`; IF/ID is loaded with a bubble (`instr_id=0`, `pc_plus4_id=0`, `valid_id=0`); the fetched word is discarded and not counted.
  4. normal: `pc <= pc+4`; IF/ID gets `{imem_data, pc+4}`, valid; `instr_count` increments.
- HALT accept happens in the normal case when `imem_data[31:26]==HALT_OPCODE`:
  - the HALT instruction enters IF/ID valid and is counted;
  - PC is frozen at the HALT address;
  - state becomes HALTED and `halted` rises.
- In HALTED, IF/ID loads a bubble every cycle, so the HALT instruction is seen in ID for exactly one cycle.
- A HALT present in IF during stall is not accepted until the stall drops. A HALT present in IF during a redirect is squashed and the block stays in RUN.
- Arithmetic: `pc+4` and `instr_count` wrap modulo 2^32. Addresses above the memory depth alias via `imem_addr` truncation.
- `stall` is honoured for a single cycle or for consecutive cycles; the block has no internal limit.

## Timing
- Reset values: `pc=RESET_PC`, `instr_id=0`, `pc_plus4_id=0`, `valid_id=0`, `nop_id=1`, `halted=0`, `instr_count=0`, state RUN.
- `imem_addr` follows `pc` combinationally, with zero latency.
- The instruction at PC appears on `instr_id` one posedge after PC is presented.
- After a redirect at edge N:
  - the target address is on `imem_addr` after N;
  - the bubble is in IF/ID after N;
  - the target instruction is in IF/ID after N+1.
- `halted` asserts at the same edge that latches HALT into IF/ID.
- Reset asserted mid-stall, mid-redirect, or while HALTED restores all reset values at the next posedge; fetch of `RESET_PC` appears in IF/ID one edge after reset deasserts.

## Structure
- Shared `mips_pkg` holds:
  - `NOP_INSTR` (32'h0);
  - `HALT_OPCODE` default;
  - opcode field bounds `[31:26]`;
  - `WORD_W=32`.
  The `HALT_OPCODE` parameter is seeded from the package.
- One sub-module, `fetch_pc_unit`, contains the PC register, the next-PC mux (stall/jump/branch/+4/halt-freeze), and the target alignment. `fetch_stage` itself holds the RUN/HALTED state, the IF/ID register, and the counter.

## Test plan
- **Sequential fetch:** reset, then a memory of 4 ADD words. Required: `instr_id` shows words 0..3 on edges 2..5; `pc_plus4_id`=4,8,12,16; `instr_count`=4.
- **Stall:** `stall` high for 2 cycles while PC=8. Required: `imem_addr`=2 held; IF/ID holds the word at 4; count is unchanged; fetch resumes at 8.
- **Branch flush:** `branch_taken` with `branch_target=0x40` at PC=0x10. Required: next IF/ID shows a bubble (`nop_id=1`); the following IF/ID shows the word at 0x40 with `pc_plus4_id=0x44`.
- **Jump vs branch and stall vs redirect:**
  - jump (0x80) and branch (0x40) asserted together: required next PC=0x80;
  - `branch_taken` with `stall`: required PC held and no flush.
- **HALT:** HALT at address 0x0C. Required:
  - HALT appears valid in IF/ID once and `halted=1` on that same edge;
  - `imem_addr` stays at 3;
  - bubbles follow;
  - later redirects are ignored.
- **Reset while HALTED and unaligned target:** after reset, PC=`RESET_PC` and `halted=0`. A `jump_target` of 0x103 is then required to fetch from 0x100.
